// File: rtl/cpm_topk_stream_if.sv
// Stream-in / ranked-result-out bundle for cpm_topk_stream.
// slave = the top-K block; master = whoever feeds elements and takes results.
interface cpm_topk_stream_if #(
    parameter int DATA_DW  = 8,
    parameter int INFO_DW  = 8,
    parameter int TOPK_NUM = 32
);
    localparam int CNT_W = $clog2(TOPK_NUM + 1);

    logic                               IN_VLD;
    logic                               IN_RDY;
    logic                               IN_LST;
    logic [DATA_DW-1:0]                 IN_DAT;
    logic [INFO_DW-1:0]                 IN_INF;
    logic                               OUT_VLD;
    logic                               OUT_RDY;
    logic [TOPK_NUM-1:0][DATA_DW-1:0]   OUT_DAT;
    logic [TOPK_NUM-1:0][INFO_DW-1:0]   OUT_INF;
    logic [CNT_W-1:0]                   OUT_CNT;
`ifdef CPM_TOPK_MASK_EN
    logic [TOPK_NUM-1:0]                OUT_MSK;
`endif

    modport master (
        output IN_VLD, IN_LST, IN_DAT, IN_INF, OUT_RDY,
`ifdef CPM_TOPK_MASK_EN
        input  OUT_MSK,
`endif
        input  IN_RDY, OUT_VLD, OUT_DAT, OUT_INF, OUT_CNT
    );

    modport slave (
        input  IN_VLD, IN_LST, IN_DAT, IN_INF, OUT_RDY,
`ifdef CPM_TOPK_MASK_EN
        output OUT_MSK,
`endif
        output IN_RDY, OUT_VLD, OUT_DAT, OUT_INF, OUT_CNT
    );
endinterface

// File: rtl/cpm_topk_stream.sv
// Streaming top-K selector: keeps the K best keys (with tags) of a batch in a sorted array.
// Optional occupancy mask output OUT_MSK is enabled by defining CPM_TOPK_MASK_EN.
module cpm_topk_stream #(
    parameter int DATA_DW  = 8,
    parameter int INFO_DW  = 8,
    parameter int TOPK_NUM = 32,
    parameter int DATA_SGN = 0,
    parameter int SORT_MIN = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    cpm_topk_stream_if.slave   bus
);
    localparam int               CNT_W    = $clog2(TOPK_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOPK_NUM);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_DW-1:0]  dat_q [TOPK_NUM];
    logic [DATA_DW-1:0]  dat_d [TOPK_NUM];
    logic [DATA_DW-1:0]  shift_dat [TOPK_NUM];
    logic [INFO_DW-1:0]  inf_q [TOPK_NUM];
    logic [INFO_DW-1:0]  inf_d [TOPK_NUM];
    logic [INFO_DW-1:0]  shift_inf [TOPK_NUM];
    logic [TOPK_NUM-1:0] keep;
    logic                accept;

    // True when stored key a ranks ahead of, or ties with, incoming key b.
    function automatic logic beats_or_eq(input logic [DATA_DW-1:0] a,
                                         input logic [DATA_DW-1:0] b);
        logic lt;
        if (DATA_SGN != 0) lt = $signed(a) < $signed(b);
        else               lt = a < b;
        if (SORT_MIN != 0) return lt || (a == b);
        else               return !lt;
    endfunction

    assign accept      = bus.IN_VLD && bus.IN_RDY;
    assign bus.IN_RDY  = (state_q != DONE);
    assign bus.OUT_VLD = (state_q == DONE);
    assign bus.OUT_CNT = cnt_q;

    // keep[] is a run of ones over the occupied prefix that outranks the new key;
    // the first zero is the insertion slot, everything after it moves down one.
    genvar gi;
    for (gi = 0; gi < TOPK_NUM; gi++) begin : g_slot
        assign keep[gi] = (CNT_W'(gi) < cnt_q) && beats_or_eq(dat_q[gi], bus.IN_DAT);
        if (gi == 0) begin : g_head
            assign shift_dat[gi] = keep[gi] ? dat_q[gi] : bus.IN_DAT;
            assign shift_inf[gi] = keep[gi] ? inf_q[gi] : bus.IN_INF;
        end else begin : g_body
            assign shift_dat[gi] = keep[gi]   ? dat_q[gi]  :
                                   keep[gi-1] ? bus.IN_DAT : dat_q[gi-1];
            assign shift_inf[gi] = keep[gi]   ? inf_q[gi]  :
                                   keep[gi-1] ? bus.IN_INF : inf_q[gi-1];
        end
    end

    always_comb begin
        for (int i = 0; i < TOPK_NUM; i++) begin
            bus.OUT_DAT[i] = dat_q[i];
            bus.OUT_INF[i] = inf_q[i];
        end
    end

`ifdef CPM_TOPK_MASK_EN
    always_comb begin
        for (int i = 0; i < TOPK_NUM; i++) begin
            bus.OUT_MSK[i] = (CNT_W'(i) < cnt_q);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        inf_d   = inf_q;
        unique case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    // A full array whose every slot outranks the key leaves shift_* unchanged.
                    dat_d = shift_dat;
                    inf_d = shift_inf;
                    if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
                    state_d = bus.IN_LST ? DONE : FILL;
                end
            end
            DONE: begin
                if (bus.OUT_RDY) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    for (int i = 0; i < TOPK_NUM; i++) begin
                        dat_d[i] = '0;
                        inf_d[i] = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < TOPK_NUM; i++) begin
                dat_q[i] <= '0;
                inf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            inf_q   <= inf_d;
        end
    end
endmodule

// File: tb/tb_cpm_topk_stream.sv
// Bench for cpm_topk_stream: two K=4 instances (unsigned/largest and signed/smallest),
// directed table and sequences plus random batches against a stable-sort reference.
module tb_cpm_topk_stream;
    localparam int K = 4;

    logic       clk = 1'b0;
    logic       rst_n, sel, vld, lst, ordy, clr;
    logic [7:0] dat, inf;
    int         nvec = 0;
    int         nmis = 0;

    typedef struct { logic [7:0] key; logic [7:0] tag; } elem_t;
    elem_t mq[$];

    always #5 clk = ~clk;

    cpm_topk_stream_if #(.DATA_DW(8), .INFO_DW(8), .TOPK_NUM(K)) if_a ();
    cpm_topk_stream_if #(.DATA_DW(8), .INFO_DW(8), .TOPK_NUM(K)) if_b ();

    logic clr_a, clr_b;
    assign clr_a = clr & ~sel;
    assign clr_b = clr & sel;

    cpm_topk_stream #(.DATA_DW(8), .INFO_DW(8), .TOPK_NUM(K), .DATA_SGN(0), .SORT_MIN(0))
        u_max (.clk(clk), .rst_n(rst_n), .clear(clr_a), .bus(if_a.slave));
    cpm_topk_stream #(.DATA_DW(8), .INFO_DW(8), .TOPK_NUM(K), .DATA_SGN(1), .SORT_MIN(1))
        u_min (.clk(clk), .rst_n(rst_n), .clear(clr_b), .bus(if_b.slave));

    assign if_a.IN_VLD  = vld & ~sel;
    assign if_b.IN_VLD  = vld & sel;
    assign if_a.OUT_RDY = ordy & ~sel;
    assign if_b.OUT_RDY = ordy & sel;
    assign if_a.IN_LST  = lst;
    assign if_b.IN_LST  = lst;
    assign if_a.IN_DAT  = dat;
    assign if_b.IN_DAT  = dat;
    assign if_a.IN_INF  = inf;
    assign if_b.IN_INF  = inf;

    logic                obs_rdy, obs_vld;
    logic [2:0]          obs_cnt;
    logic [K-1:0][7:0]   obs_dat, obs_inf;
    assign obs_rdy = sel ? if_b.IN_RDY  : if_a.IN_RDY;
    assign obs_vld = sel ? if_b.OUT_VLD : if_a.OUT_VLD;
    assign obs_cnt = sel ? if_b.OUT_CNT : if_a.OUT_CNT;
    assign obs_dat = sel ? if_b.OUT_DAT : if_a.OUT_DAT;
    assign obs_inf = sel ? if_b.OUT_INF : if_a.OUT_INF;
`ifdef CPM_TOPK_MASK_EN
    logic [K-1:0] obs_msk;
    assign obs_msk = sel ? if_b.OUT_MSK : if_a.OUT_MSK;
`endif

    task automatic chk(input string nm, input int act, input int req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t sel=%0d)", nm, act, req, $time, sel);
        end
    endtask

    // Strict "ranks ahead" in the selected instance's ordering.
    function automatic bit beats(input logic [7:0] a, input logic [7:0] b);
        if (sel) return $signed(a) < $signed(b);
        return a > b;
    endfunction

    task automatic send(input logic [7:0] k, input logic [7:0] t, input logic l);
        chk("in_rdy_pre", int'(obs_rdy), 1);
        vld = 1'b1; dat = k; inf = t; lst = l;
        @(posedge clk); #1;
        vld = 1'b0; lst = 1'b0;
        mq.push_back('{k, t});
        chk("cnt_run", int'(obs_cnt), (mq.size() < K) ? mq.size() : K);
        $display("send sel=%0d key=%02h tag=%02h lst=%0d cnt=%0d", sel, k, t, l, obs_cnt);
    endtask

    // Reference: stable selection of the K best from the whole batch; absent slots read 0.
    task automatic check_result(input string nm);
        int   n;
        int   best;
        bit   used[];
        int   ed[K];
        int   ei[K];
        n = mq.size();
        used = new[n];
        for (int s = 0; s < K; s++) begin
            best = -1;
            for (int j = 0; j < n; j++)
                if (!used[j] && (best < 0 || beats(mq[j].key, mq[best].key))) best = j;
            if (best >= 0) begin
                used[best] = 1'b1;
                ed[s] = int'(mq[best].key);
                ei[s] = int'(mq[best].tag);
            end else begin
                ed[s] = 0;
                ei[s] = 0;
            end
        end
        chk({nm, ".vld"}, int'(obs_vld), 1);
        chk({nm, ".rdy"}, int'(obs_rdy), 0);
        chk({nm, ".cnt"}, int'(obs_cnt), (n < K) ? n : K);
        for (int s = 0; s < K; s++) begin
            chk($sformatf("%s.dat%0d", nm, s), int'(obs_dat[s]), ed[s]);
            chk($sformatf("%s.inf%0d", nm, s), int'(obs_inf[s]), ei[s]);
        end
`ifdef CPM_TOPK_MASK_EN
        chk({nm, ".msk"}, int'(obs_msk), (1 << ((n < K) ? n : K)) - 1);
`endif
        $display("result %s sel=%0d n=%0d dat=%08h inf=%08h cnt=%0d", nm, sel, n, obs_dat, obs_inf, obs_cnt);
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, ".cnt"}, int'(obs_cnt), 0);
        chk({nm, ".vld"}, int'(obs_vld), 0);
        chk({nm, ".rdy"}, int'(obs_rdy), 1);
        chk({nm, ".dat"}, int'(obs_dat), 0);
        chk({nm, ".inf"}, int'(obs_inf), 0);
`ifdef CPM_TOPK_MASK_EN
        chk({nm, ".msk"}, int'(obs_msk), 0);
`endif
    endtask

    task automatic release_out(input string nm);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0; vld = 1'b0;
        chk_empty(nm);
        mq.delete();
    endtask

    typedef struct {
        logic [7:0] key;
        logic [7:0] tag;
        logic       lst;
        int         cnt;
        int         s0;
        int         ovld;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[5];
        int   e_d[K];
        int   e_i[K];
        int   n;
        logic [7:0] k;

        tab[0] = '{8'd5, 8'd0, 1'b0, 1, 5, 0};
        tab[1] = '{8'd9, 8'd1, 1'b0, 2, 9, 0};
        tab[2] = '{8'd1, 8'd2, 1'b0, 3, 9, 0};
        tab[3] = '{8'd7, 8'd3, 1'b0, 4, 9, 0};
        tab[4] = '{8'd3, 8'd4, 1'b1, 4, 9, 1};
        e_d = '{9, 7, 5, 3};
        e_i = '{1, 3, 0, 4};

        rst_n = 1'b0; sel = 1'b0; vld = 1'b0; lst = 1'b0; ordy = 1'b0; clr = 1'b0;
        dat = '0; inf = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_empty("rst_a");
        sel = 1'b1; #1; chk_empty("rst_b"); sel = 1'b0;
        rst_n = 1'b1;

        // Scenario: 5,9,1,7,3 table-driven
        for (int i = 0; i < 5; i++) begin
            chk("s1.vld_pre", int'(obs_vld), 0);
            send(tab[i].key, tab[i].tag, tab[i].lst);
            chk("s1.cnt", int'(obs_cnt), tab[i].cnt);
            chk("s1.s0", int'(obs_dat[0]), tab[i].s0);
            chk("s1.vld", int'(obs_vld), tab[i].ovld);
        end
        for (int s = 0; s < K; s++) begin
            chk($sformatf("s1.dat%0d", s), int'(obs_dat[s]), e_d[s]);
            chk($sformatf("s1.inf%0d", s), int'(obs_inf[s]), e_i[s]);
        end
        check_result("s1");

        // Hold in DONE with a pending input; nothing may change
        vld = 1'b1; dat = 8'hEE; inf = 8'h77;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold.rdy", int'(obs_rdy), 0);
            chk("hold.vld", int'(obs_vld), 1);
            chk("hold.cnt", int'(obs_cnt), 4);
            chk("hold.dat", int'(obs_dat), 32'h03050709);
            chk("hold.inf", int'(obs_inf), 32'h04000301);
            $display("hold cycle %0d rdy=%0d cnt=%0d", c, obs_rdy, obs_cnt);
        end
        release_out("hold.rel");

        // Equal keys keep arrival order
        send(8'd6, 8'hA, 1'b0);
        send(8'd6, 8'hB, 1'b1);
        chk("tie.d0", int'(obs_dat[0]), 6);  chk("tie.i0", int'(obs_inf[0]), 8'hA);
        chk("tie.d1", int'(obs_dat[1]), 6);  chk("tie.i1", int'(obs_inf[1]), 8'hB);
        chk("tie.d2", int'(obs_dat[2]), 0);  chk("tie.d3", int'(obs_dat[3]), 0);
        chk("tie.cnt", int'(obs_cnt), 2);
        check_result("tie");
        release_out("tie.rel");

        // Signed, keep smallest
        sel = 1'b1; #1;
        send(8'h05, 8'd0, 1'b0);
        send(8'hFE, 8'd1, 1'b0);
        send(8'h80, 8'd2, 1'b0);
        send(8'h00, 8'd3, 1'b1);
        chk("sgn.dat", int'(obs_dat), 32'h0500FE80);
        check_result("sgn");
        release_out("sgn.rel");
        sel = 1'b0; #1;

        // clear together with an accepted element
        send(8'd3, 8'd1, 1'b0);
        send(8'd8, 8'd2, 1'b0);
        vld = 1'b1; dat = 8'd7; inf = 8'd3; clr = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; clr = 1'b0;
        chk_empty("clr");
        mq.delete();
        send(8'd4, 8'd5, 1'b1);
        chk("clr.cnt1", int'(obs_cnt), 1);
        chk("clr.s0", int'(obs_dat[0]), 4);
        check_result("clr1");
        release_out("clr.rel");

        // Reset mid-batch, then reset in DONE
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        chk_empty("rst_mid");
        mq.delete();
        send(8'd9, 8'd9, 1'b1);
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        chk_empty("rst_done");
        mq.delete();

        // Random batches on both instances
        for (int sv = 0; sv < 2; sv++) begin
            sel = sv[0]; #1;
            for (int b = 0; b < 30; b++) begin
                n = $urandom_range(1, 9);
                for (int j = 0; j < n; j++) begin
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    if ($urandom_range(0, 1) == 0) k = 8'($urandom_range(0, 7));
                    else                           k = 8'($urandom_range(0, 255));
                    send(k, 8'(j + 16 * (b % 16)), (j == n - 1) ? 1'b1 : 1'b0);
                end
                check_result("rnd");
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                chk("rnd.vld_hold", int'(obs_vld), 1);
                release_out("rnd.rel");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/cpm_topk_stream.md
CPM_TOPK_STREAM -- requirements
Module: cpm_topk_stream

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_DW, 8, key width.
- INFO_DW, 8, tag width.
- TOPK_NUM, 32, retained entries K (K >= 2).
- DATA_SGN, 0, keys unsigned (0) or two's complement (1).
- SORT_MIN, 0, keep largest K (0) or smallest K (1).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset.
- clear, in, 1, synchronous flush.
- IN_VLD, in, 1, input valid.
- IN_RDY, out, 1, input ready.
- IN_LST, in, 1, last element of the batch.
- IN_DAT, in, DATA_DW, key.
- IN_INF, in, INFO_DW, tag.
- OUT_VLD, out, 1, result valid.
- OUT_RDY, in, 1, result accepted.
- OUT_DAT, out, TOPK_NUM x DATA_DW, ranked keys; slot 0 is best.
- OUT_INF, out, TOPK_NUM x INFO_DW, tags paired with OUT_DAT.
- OUT_CNT, out, clog2(TOPK_NUM+1), number of occupied slots.
REQ-003 One clock domain SHALL be used; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 An input element SHALL be accepted on any rising edge where IN_VLD && IN_RDY.
REQ-005 The FSM SHALL have the states IDLE, FILL and DONE:
- IDLE -> FILL on an accepted element without IN_LST.
- IDLE/FILL -> DONE on an accepted element with IN_LST.
- DONE -> IDLE on OUT_RDY.
REQ-006 IN_RDY SHALL be 1 in IDLE and FILL and 0 in DONE; OUT_VLD SHALL be 1 only in DONE.
REQ-007 The insertion rank r SHALL be the number of occupied slots whose key beats or equals the new key. "Beats" means greater for SORT_MIN=0 and less for SORT_MIN=1, compared signed when DATA_SGN=1.
REQ-008 On acceptance with r < TOPK_NUM:
- slot r SHALL load the new key and tag.
- slots r+1..K-1 SHALL shift down by one.
- the old slot K-1 SHALL be dropped.
REQ-009 On acceptance with r == TOPK_NUM the element SHALL be discarded and the array left unchanged.
REQ-010 Ties SHALL be stable: an earlier-accepted equal key always ranks ahead of a later one.
REQ-011 Empty slots SHALL never be compared; any element is accepted while OUT_CNT < TOPK_NUM.
REQ-012 OUT_CNT SHALL increment on each non-discarded acceptance and saturate at TOPK_NUM.
REQ-013 The array update SHALL take effect at the accepting edge. OUT_VLD SHALL assert in the cycle after the IN_LST acceptance and show the fully updated array.
REQ-014 In DONE, OUT_DAT, OUT_INF and OUT_CNT SHALL hold stable until OUT_RDY.
REQ-015 On the OUT_RDY edge in DONE, all slots and OUT_CNT SHALL clear to 0, so the next batch starts empty.
REQ-016 If IN_LST arrives on the first element of a batch, OUT_CNT SHALL be 1 in DONE.
REQ-017 clear SHALL take priority over every other event, including simultaneous acceptance and OUT_RDY. It SHALL zero all slots and OUT_CNT and force IDLE, and the element presented on that edge SHALL be ignored.

Reset
REQ-018 When rst_n=0 at a rising edge, the block SHALL enter IDLE and zero OUT_DAT, OUT_INF and OUT_CNT; OUT_VLD SHALL be 0 and IN_RDY SHALL be 1.
REQ-019 Reset asserted mid-batch or in DONE SHALL discard all partial results, with no OUT_VLD pulse.

Configuration
REQ-020 With macro CPM_TOPK_MASK_EN defined, the block SHALL add output OUT_MSK [TOPK_NUM], where bit i is 1 iff slot i is occupied. OUT_MSK SHALL be zeroed by reset, clear and the OUT_RDY edge in DONE.
REQ-021 Without CPM_TOPK_MASK_EN, OUT_MSK SHALL not exist, and unoccupied slots SHALL read DATA 0 and INFO 0.

Verification
REQ-022 The bench SHALL cover these scenarios (K=4, unsigned, SORT_MIN=0 unless stated):
- Feed 5,9,1,7,3 (tags 0..4), LST on 3 -> OUT_DAT 9,7,5,3; OUT_INF 1,3,0,4; OUT_CNT 4; OUT_VLD in the cycle after LST.
- Feed 6(tag A), 6(tag B), LST -> slot0=6/A, slot1=6/B, OUT_CNT 2, slots 2-3 are 0 (OUT_MSK=0011 when the macro is defined).
- SORT_MIN=1, DATA_SGN=1; feed 8'h05, 8'hFE, 8'h80, 8'h00 with LST -> OUT_DAT 80,FE,00,05.
- Hold OUT_RDY=0 for 10 cycles in DONE with IN_VLD=1 -> IN_RDY=0, outputs stable. Then OUT_RDY=1 -> next cycle IDLE, OUT_CNT 0, IN_RDY 1.
- Assert clear together with an accepted element mid-batch -> array zero and IDLE; a subsequent single element 4 with LST -> OUT_CNT 1, slot0=4.
